// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe
//   Pipelined instruction store for the fetch side of the CPU datapath.
//   The fetch stage sends byte addresses over a valid/ready request channel.
//   Instruction words return LATENCY cycles later over a valid/ready response
//   channel that supports backpressure. Misaligned fetches and out-of-range
//   fetches are flagged, and a faulted response carries a NOP (0). A
//   word-indexed load port writes the program at run time. Contents
//   initialise to all zero.
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o       request handshake
//   req_addr_i[31:0]              byte address of the fetch
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_instr_o[DATA_W-1:0]       fetched word (0 on fault)
//   rsp_fault_o[1:0]              00 ok, 01 misaligned, 10 out of range
//   ld_we_i, ld_addr_i, ld_data_i load-port write (blocks request acceptance)
//   fetch_cnt_o[15:0]             responses consumed, wraps
module instr_mem_pipe #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 32,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_W-1:0]        rsp_instr_o,
  output logic [1:0]               rsp_fault_o,
  input  logic                     ld_we_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [DATA_W-1:0]        ld_data_i,
  output logic [15:0]              fetch_cnt_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_pipe: LATENCY must be in 1..4");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_mem_pipe: DEPTH must be a power of two, at least 4");
  end

  // Storage. The array is never reset; contents survive rst_i.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
  end

  // Pipeline stages. Index 0 is stage 1, which is captured at acceptance.
  // Index LATENCY-1 is the output register.
  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  instr_q [LATENCY];
  logic [1:0]         fault_q [LATENCY];
  logic [15:0]        fetch_cnt_q, fetch_cnt_d;

  logic              advance, accept;
  logic [1:0]        fault;
  logic [1:0]        s1_fault_d;
  logic [DATA_W-1:0] s1_instr_d;

  assign rsp_valid_o = vld_q[LATENCY-1];
  assign rsp_instr_o = instr_q[LATENCY-1];
  assign rsp_fault_o = fault_q[LATENCY-1];
  assign fetch_cnt_o = fetch_cnt_q;

  // The whole pipe moves as one unit. A stalled output freezes every stage,
  // bubbles included. This keeps the stall-to-latency relation exact.
  assign advance     = !rsp_valid_o || rsp_ready_i;
  assign req_ready_o = rst_i && advance && !ld_we_i;
  assign accept      = req_valid_i && req_ready_o;

  // Misalignment wins over range.
  always_comb begin
    fault = 2'b00;
    if (req_addr_i[1:0] != 2'b00)      fault = 2'b01;
    else if (req_addr_i[31:2] >= DEPTH_W) fault = 2'b10;
  end

  // A faulted fetch or a bubble carries a zero word, so no read occurs.
  always_comb begin
    s1_fault_d = accept ? fault : 2'b00;
    s1_instr_d = '0;
    if (accept && fault == 2'b00) s1_instr_d = mem[req_addr_i[AW+1:2]];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        instr_q[k] <= '0;
        fault_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0]   <= accept;
      instr_q[0] <= s1_instr_d;
      fault_q[0] <= s1_fault_d;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k]   <= vld_q[k-1];
        instr_q[k] <= instr_q[k-1];
        fault_q[k] <= fault_q[k-1];
      end
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (rsp_valid_o && rsp_ready_i) fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe
//   Bench for instr_mem_pipe. It drives a LATENCY=2 instance through a table of
//   per-cycle vectors: back-to-back fetch, backpressure, faults, and load/read
//   ordering. A LATENCY=4 instance covers reset asserted mid-flight and memory
//   retention across that reset. The counter wrap is driven by forcing the
//   count register.
module tb_instr_mem_pipe;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, ld_we;
  logic [31:0] req_addr, rsp_instr, ld_data;
  logic [1:0]  rsp_fault;
  logic [4:0]  ld_addr;
  logic [15:0] fetch_cnt;

  // LATENCY=4 instance
  logic        rst4_n, req_valid4, req_ready4, rsp_valid4, rsp_ready4, ld_we4;
  logic [31:0] req_addr4, rsp_instr4, ld_data4;
  logic [1:0]  rsp_fault4;
  logic [4:0]  ld_addr4;
  logic [15:0] fetch_cnt4;

  instr_mem_pipe #(.DATA_W(32), .DEPTH(32), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_instr_o(rsp_instr),
    .rsp_fault_o(rsp_fault), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .fetch_cnt_o(fetch_cnt)
  );

  instr_mem_pipe #(.DATA_W(32), .DEPTH(32), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst4_n),
    .req_valid_i(req_valid4), .req_ready_o(req_ready4), .req_addr_i(req_addr4),
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4), .rsp_instr_o(rsp_instr4),
    .rsp_fault_o(rsp_fault4), .ld_we_i(ld_we4), .ld_addr_i(ld_addr4),
    .ld_data_i(ld_data4), .fetch_cnt_o(fetch_cnt4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic        rdy;
    logic        we;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_rr;
    logic        e_rv;
    logic [31:0] e_ins;
    logic [1:0]  e_flt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic v, input logic [31:0] addr, input logic rdy,
                     input logic we, input logic [4:0] la, input logic [31:0] ld,
                     input logic e_rr, input logic e_rv, input logic [31:0] e_ins,
                     input logic [1:0] e_flt, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.addr = addr; t.rdy = rdy; t.we = we; t.la = la; t.ld = ld;
    t.e_rr = e_rr; t.e_rv = e_rv; t.e_ins = e_ins; t.e_flt = e_flt; t.e_cnt = e_cnt;
    vt.push_back(t);
  endtask

  task automatic load_both(input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] d4);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    ld_we4 = 1'b1; ld_addr4 = a; ld_data4 = d4;
  endtask

  initial begin
    int          lat;
    logic [31:0] got;
    logic        stale;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    rst4_n = 1'b0; req_valid4 = 1'b0; req_addr4 = '0; rsp_ready4 = 1'b1;
    ld_we4 = 1'b0; ld_addr4 = '0; ld_data4 = '0;

    // The program is loaded while both instances are held in reset.
    load_both(5'd0,  32'h20080005, 32'hA0000001);
    load_both(5'd1,  32'h20090003, 32'hB0000002);
    load_both(5'd2,  32'h01095020, 32'hC0000003);
    load_both(5'd3,  32'h00000000, 32'h0);
    load_both(5'd5,  32'h55555555, 32'h0);
    load_both(5'd31, 32'h1234ABCD, 32'h0);
    @(negedge clk);
    ld_we = 1'b0; ld_we4 = 1'b0;
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_instr", rsp_instr, 32'd0);
    chk("reset rsp_fault", {30'd0, rsp_fault}, 32'd0);
    chk("reset fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
    chk("reset4 rsp_valid", {31'd0, rsp_valid4}, 32'd0);

    // Each row covers one cycle. Inputs are driven at the negedge. Expected
    // outputs are the state after the previous rising edge; req_ready is
    // combinational on this row's inputs.
    //   v  addr          rdy we la  ld             rr rv ins           flt  cnt
    add(1, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    add(1, 32'h04, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    add(1, 32'h08, 1, 0, 0, 32'h0,        1, 1, 32'h20080005, 0, 0);
    add(1, 32'h0C, 1, 0, 0, 32'h0,        1, 1, 32'h20090003, 0, 1);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h01095020, 0, 2);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h00000000, 0, 3);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 4);
    // Backpressure: three stalled cycles on the first response.
    add(1, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 4);
    add(1, 32'h04, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 4);
    add(1, 32'h08, 0, 0, 0, 32'h0,        0, 1, 32'h20080005, 0, 4);
    add(1, 32'h08, 0, 0, 0, 32'h0,        0, 1, 32'h20080005, 0, 4);
    add(1, 32'h08, 0, 0, 0, 32'h0,        0, 1, 32'h20080005, 0, 4);
    add(1, 32'h08, 1, 0, 0, 32'h0,        1, 1, 32'h20080005, 0, 4);
    add(1, 32'h0C, 1, 0, 0, 32'h0,        1, 1, 32'h20090003, 0, 5);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h01095020, 0, 6);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h00000000, 0, 7);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 8);
    // Faults: misaligned, out of range, last word, then both at once.
    add(1, 32'h06, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 8);
    add(1, 32'h80, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 8);
    add(1, 32'h7C, 1, 0, 0, 32'h0,        1, 1, 32'h0,        1, 8);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h0,        2, 9);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h1234ABCD, 0, 10);
    add(1, 32'h81, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 11);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 11);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h0,        1, 11);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 12);
    // A load blocks the held request. The request then sees the new word.
    add(1, 32'h14, 1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 12);
    add(1, 32'h14, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 12);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 12);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 12);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 13);
    // A word already in flight is unaffected by a later write.
    add(1, 32'h14, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 13);
    add(0, 32'h00, 1, 1, 5, 32'h0BADF00D, 0, 0, 32'h0,        0, 13);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 13);
    add(1, 32'h14, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 14);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 14);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 1, 32'h0BADF00D, 0, 14);
    add(0, 32'h00, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 15);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      req_valid = vt[i].v; req_addr = vt[i].addr; rsp_ready = vt[i].rdy;
      ld_we = vt[i].we; ld_addr = vt[i].la; ld_data = vt[i].ld;
      #1;
      chk($sformatf("vec%0d req_ready", i), {31'd0, req_ready}, {31'd0, vt[i].e_rr});
      chk($sformatf("vec%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vt[i].e_rv});
      if (vt[i].e_rv) begin
        chk($sformatf("vec%0d rsp_instr", i), rsp_instr, vt[i].e_ins);
        chk($sformatf("vec%0d rsp_fault", i), {30'd0, rsp_fault}, {30'd0, vt[i].e_flt});
      end
      chk($sformatf("vec%0d fetch_cnt", i), {16'd0, fetch_cnt}, {16'd0, vt[i].e_cnt});
    end

    // Counter wrap: preload 0xFFFF, then consume one response.
    @(negedge clk);
    req_valid = 1'b0; ld_we = 1'b0; rsp_ready = 1'b1;
    force dut.fetch_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fetch_cnt_q;
    req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap pre rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wrap pre fetch_cnt", {16'd0, fetch_cnt}, 32'h0000FFFF);
    @(negedge clk);
    #1;
    chk("wrap fetch_cnt", {16'd0, fetch_cnt}, 32'd0);

    // Reset mid-flight on the LATENCY=4 instance.
    @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk); req_valid4 = 1'b1; req_addr4 = 32'h0;
    #1 chk("l4 req_ready", {31'd0, req_ready4}, 32'd1);
    @(negedge clk); req_addr4 = 32'h4;
    @(negedge clk); req_addr4 = 32'h8;
    @(negedge clk); req_valid4 = 1'b0;
    #1 chk("l4 early rsp_valid", {31'd0, rsp_valid4}, 32'd0);
    @(negedge clk);
    #1;
    chk("l4 first rsp_valid", {31'd0, rsp_valid4}, 32'd1);
    chk("l4 first rsp_instr", rsp_instr4, 32'hA0000001);
    @(negedge clk);
    #1;
    chk("l4 second rsp_instr", rsp_instr4, 32'hB0000002);
    chk("l4 cnt before reset", {16'd0, fetch_cnt4}, 32'd1);
    #1 rst4_n = 1'b0;
    #1;
    chk("l4 reset rsp_valid", {31'd0, rsp_valid4}, 32'd0);
    chk("l4 reset fetch_cnt", {16'd0, fetch_cnt4}, 32'd0);
    chk("l4 reset req_ready", {31'd0, req_ready4}, 32'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid4) stale = 1'b1;
    end
    chk("l4 no stale rsp", {31'd0, stale}, 32'd0);

    // Memory survives reset; the response lands after exactly LATENCY cycles.
    req_valid4 = 1'b1; req_addr4 = 32'h8;
    lat = 0; got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid4 = 1'b0;
      #1;
      if (rsp_valid4 && lat == 0) begin
        lat = k;
        got = rsp_instr4;
      end
    end
    chk("l4 post-reset latency", lat, 32'd4);
    chk("l4 retained word", got, 32'hC0000003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
